button_event_arbiter: RTL and testbench

//  - Debounces N_KEYS push buttons using one shared sample tick. The tick is a clock enable on clk; no derived clock.
//  - Turns each debounced press (0->1 of the stable level) into a pending event.
//  - A round-robin arbiter hands pending events one at a time to a single consumer over a valid/ready handshake.
//  - Sits between the board push buttons and the control FSMs that act on key presses.

---
 rtl/btn_pkg.sv | 18 +
 rtl/key_debounce_lane.sv | 54 +++++
 rtl/button_event_arbiter.sv | 120 ++++++++++++
 tb/tb_button_event_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event arbiter.
//  - arb_state_t : two-state arbiter encoding (ST_IDLE / ST_OFFER)
//  - clog2       : width helper; never returns less than 1 so single-value fields stay legal
package btn_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// One debounce lane: 2-flop synchronizer, stability counter, level register, rise pulse.
// Ports:
//  clk, rst : system clock, synchronous active-high reset
//  key      : raw asynchronous button input
//  tick     : shared sample enable (one clk wide)
//  level    : debounced level (registered)
//  rise_c   : combinational pulse in the clk where level is about to go 0->1
module key_debounce_lane
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic tick,
    output logic level,
    output logic rise_c
);

    localparam int unsigned CNT_W = clog2(STABLE_TICKS);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             sample;
    logic             at_limit;

    assign sample   = sync[1];
    assign at_limit = (cnt == CNT_W'(STABLE_TICKS - 1));

    // Level flips only on the STABLE_TICKS-th consecutive disagreeing tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], key};
            if (tick) begin
                if (sample == level) begin
                    cnt <= '0;
                end else if (at_limit) begin
                    level <= sample;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rise_c = tick & sample & ~level & at_limit;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced push-button press events, handed out one at a time in round-robin order.
// Ports:
//  clk, rst   : system clock, synchronous active-high reset
//  key        : raw button inputs, 1 = pressed
//  key_level  : debounced level per key
//  ev_valid   : event offered to the consumer
//  ev_id      : index of the key whose press is offered
//  ev_ready   : consumer accepts when ev_valid & ev_ready
//  ev_overrun : 1-clk pulse when a press hits a key that is already pending
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned TICK_DIV     = 250000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_KEYS-1:0]          key,
    output logic [N_KEYS-1:0]          key_level,
    output logic                       ev_valid,
    output logic [clog2(N_KEYS)-1:0]   ev_id,
    input  logic                       ev_ready,
    output logic                       ev_overrun
);

    localparam int unsigned ID_W = clog2(N_KEYS);
    localparam int unsigned TW   = clog2(TICK_DIV);

    logic [TW-1:0]     tick_cnt;
    logic              tick_c;
    logic [N_KEYS-1:0] rise_c;
    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] clear_c;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_c;
    logic              grant_found_c;
    int unsigned       search_idx;
    arb_state_t        state;

    // Shared sample tick: one clk every TICK_DIV clks.
    assign tick_c = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick_c ? '0 : tick_cnt + TW'(1);
    end

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_lane
        key_debounce_lane #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .key    (key[i]),
            .tick   (tick_c),
            .level  (key_level[i]),
            .rise_c (rise_c[i])
        );
    end

    // Round-robin search starting just after the last accepted key.
    always_comb begin
        grant_c       = '0;
        grant_found_c = 1'b0;
        search_idx    = 0;
        for (int unsigned k = 1; k <= N_KEYS; k++) begin
            search_idx = (32'(last_grant) + k) % N_KEYS;
            if (!grant_found_c && pending[ID_W'(search_idx)]) begin
                grant_found_c = 1'b1;
                grant_c       = ID_W'(search_idx);
            end
        end
    end

    assign clear_c = (state == ST_IDLE && grant_found_c) ? (N_KEYS'(1) << grant_c) : '0;

    // A press in the same clk as its grant-clear wins and is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            ev_overrun <= 1'b0;
        end else begin
            pending    <= (pending & ~clear_c) | rise_c;
            ev_overrun <= |(rise_c & pending & ~clear_c);
        end
    end

    // Arbiter FSM: IDLE latches a grant, OFFER holds it until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ev_valid   <= 1'b0;
            ev_id      <= '0;
            last_grant <= ID_W'(N_KEYS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found_c) begin
                        ev_id    <= grant_c;
                        ev_valid <= 1'b1;
                        state    <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (ev_ready) begin
                        ev_valid   <= 1'b0;
                        last_grant <= ev_id;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    ev_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with TICK_DIV=4, STABLE_TICKS=3, N_KEYS=4.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [3:0] key_level;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_ready;
    logic       ev_overrun;

    int total = 0;
    int bad   = 0;
    int ovr_cnt = 0;
    logic [1:0] acc_q[$];

    button_event_arbiter #(
        .N_KEYS       (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_level  (key_level),
        .ev_valid   (ev_valid),
        .ev_id      (ev_id),
        .ev_ready   (ev_ready),
        .ev_overrun (ev_overrun)
    );

    always #5 clk = ~clk;

    // Log accepted ids and overrun pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) acc_q.push_back(ev_id);
        if (ev_overrun) ovr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        key      = 4'b0000;
        ev_ready = 1'b1;
        repeat (40) step();
    endtask

    task automatic wait_level(input logic [3:0] exp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (key_level === exp) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        int start;
        key = 4'b1111; ev_ready = 1'b1; rst = 1'b1;
        repeat (3) step();
        total++;
        if ({key_level, ev_valid, ev_id, ev_overrun} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=00", {key_level, ev_valid, ev_id, ev_overrun});
        end
        rst = 1'b0;
        start = acc_q.size();
        repeat (11) step();
        total++;
        if (key_level !== 4'b0000) begin
            bad++;
            $display("FAIL level_before_3rd_tick got=%b exp=0000", key_level);
        end
        step();
        total++;
        if (key_level !== 4'b1111) begin
            bad++;
            $display("FAIL level_on_3rd_tick got=%b exp=1111", key_level);
        end
        repeat (12) step();
        total++;
        if (acc_q.size() - start != 4) begin
            bad++;
            $display("FAIL reset_event_count got=%0d exp=4", acc_q.size() - start);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (acc_q[start + i] !== 2'(i)) begin
                    bad++;
                    $display("FAIL reset_event_order idx=%0d got=%0d exp=%0d", i, acc_q[start + i], i);
                end
            end
        end
        ok = 1'b1;
    endtask

    task automatic test_hold_offer();
        bit ok;
        bit held_bad;
        settle();
        ev_ready = 1'b0;
        key = 4'b0100;
        wait_level(4'b0100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_level_timeout got=%b exp=0100", key_level);
        end
        step();
        total++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin
            bad++;
            $display("FAIL hold_first_offer got=%b/%0d exp=1/2", ev_valid, ev_id);
        end
        held_bad = 1'b0;
        repeat (20) begin
            step();
            if (ev_valid !== 1'b1 || ev_id !== 2'd2) held_bad = 1'b1;
        end
        total++;
        if (held_bad) begin
            bad++;
            $display("FAIL hold_stable got=%b/%0d exp=1/2", ev_valid, ev_id);
        end
        ev_ready = 1'b1;
        step();
        total++;
        if (ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release got=%b exp=0", ev_valid);
        end
    endtask

    task automatic test_bounce();
        bit seen;
        settle();
        seen = 1'b0;
        key = 4'b0010;
        repeat (8) begin
            step();
            if (key_level !== 4'b0000 || ev_valid !== 1'b0) seen = 1'b1;
        end
        key = 4'b0000;
        repeat (40) begin
            step();
            if (key_level !== 4'b0000 || ev_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL bounce_filtered got=%b exp=0", seen);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int start;
        logic [5:0] vseq;
        logic [1:0] exp_ids [3];
        exp_ids = '{2'd0, 2'd1, 2'd3};
        key = 4'b0000; ev_ready = 1'b1; rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        start = acc_q.size();
        key = 4'b1011;
        wait_level(4'b1011, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL simul_level_timeout got=%b exp=1011", key_level);
        end
        for (int i = 5; i >= 0; i--) begin
            step();
            vseq[i] = ev_valid;
        end
        total++;
        if (vseq !== 6'b101010) begin
            bad++;
            $display("FAIL simul_valid_gaps got=%b exp=101010", vseq);
        end
        total++;
        if (acc_q.size() - start != 3) begin
            bad++;
            $display("FAIL simul_count got=%0d exp=3", acc_q.size() - start);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (acc_q[start + i] !== exp_ids[i]) begin
                    bad++;
                    $display("FAIL simul_order idx=%0d got=%0d exp=%0d", i, acc_q[start + i], exp_ids[i]);
                end
            end
        end
        key = 4'b1010;
        wait_level(4'b1010, ok);
        start = acc_q.size();
        key = 4'b1111;
        wait_level(4'b1111, ok);
        repeat (8) step();
        total++;
        if (acc_q.size() - start != 2) begin
            bad++;
            $display("FAIL wrap_count got=%0d exp=2", acc_q.size() - start);
        end else begin
            total++;
            if (acc_q[start] !== 2'd0 || acc_q[start + 1] !== 2'd2) begin
                bad++;
                $display("FAIL wrap_order got=%0d,%0d exp=0,2", acc_q[start], acc_q[start + 1]);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int start;
        int ovr_start;
        int n_id1;
        settle();
        ev_ready = 1'b0;
        ovr_start = ovr_cnt;
        start = acc_q.size();
        key = 4'b1000;
        wait_level(4'b1000, ok);
        step();
        total++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd3) begin
            bad++;
            $display("FAIL ovr_blocker got=%b/%0d exp=1/3", ev_valid, ev_id);
        end
        key = 4'b1010;
        wait_level(4'b1010, ok);
        key = 4'b1000;
        wait_level(4'b1000, ok);
        key = 4'b1010;
        wait_level(4'b1010, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovr_level_timeout got=%b exp=1010", key_level);
        end
        repeat (2) step();
        total++;
        if (ovr_cnt - ovr_start != 1) begin
            bad++;
            $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - ovr_start);
        end
        ev_ready = 1'b1;
        repeat (10) step();
        n_id1 = 0;
        for (int i = start; i < acc_q.size(); i++) if (acc_q[i] === 2'd1) n_id1++;
        total++;
        if (acc_q.size() - start != 2 || n_id1 != 1) begin
            bad++;
            $display("FAIL ovr_events got=%0d total,%0d id1 exp=2,1", acc_q.size() - start, n_id1);
        end
    endtask

    task automatic test_reset_mid_offer();
        bit ok;
        bit seen;
        int start;
        settle();
        ev_ready = 1'b0;
        key = 4'b1000;
        wait_level(4'b1000, ok);
        step();
        total++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd3) begin
            bad++;
            $display("FAIL rmo_offer got=%b/%0d exp=1/3", ev_valid, ev_id);
        end
        key = 4'b1001;
        wait_level(4'b1001, ok);
        key = 4'b0000;
        rst = 1'b1;
        step();
        total++;
        if (ev_valid !== 1'b0 || key_level !== 4'b0000) begin
            bad++;
            $display("FAIL rmo_drop got=%b/%b exp=0/0000", ev_valid, key_level);
        end
        step();
        rst = 1'b0;
        ev_ready = 1'b1;
        start = acc_q.size();
        seen = 1'b0;
        repeat (40) begin
            step();
            if (ev_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen || acc_q.size() != start) begin
            bad++;
            $display("FAIL rmo_no_stale got=%b/%0d exp=0/0", seen, acc_q.size() - start);
        end
        key = 4'b0001;
        wait_level(4'b0001, ok);
        repeat (4) step();
        total++;
        if (acc_q.size() - start != 1) begin
            bad++;
            $display("FAIL rmo_new_count got=%0d exp=1", acc_q.size() - start);
        end else begin
            total++;
            if (acc_q[start] !== 2'd0) begin
                bad++;
                $display("FAIL rmo_new_id got=%0d exp=0", acc_q[start]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        key = 4'b0000;
        ev_ready = 1'b0;
        test_reset();
        test_hold_offer();
        test_bounce();
        test_simultaneous();
        test_overrun();
        test_reset_mid_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
